// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling queue: buffers DEPTH (pc, instr) pairs, presents oldest to ID.
// Ports: clk, reset (async active-low), flush, in_* (IF side), out_* (ID side), count.
// Optional macro IF_ID_PREDECODE_EN stores branch/jump/load predecode bits per entry.
module if_id_fetch_queue #(
    parameter int          DEPTH     = 2,
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_instr,
    output logic                   out_is_branch,
    output logic                   out_is_jump,
    output logic                   out_is_load,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    // in_ready depends on occupancy only: a pop while full frees space next cycle.
    assign in_ready  = (cnt < FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;

    assign out_pc    = out_valid ? mem_pc[rd_ptr] : '0;
    assign out_instr = out_valid ? mem_instr[rd_ptr] : XLEN'(NOP_INSTR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Storage is not reset; entries are only visible through cnt.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

`ifdef IF_ID_PREDECODE_EN
    logic [2:0] mem_pd [DEPTH];
    logic [2:0] head_pd;
    logic [6:0] in_op;

    assign in_op = in_instr[6:0];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pd[wr_ptr] <= {in_op == 7'b1100011,
                               in_op == 7'b1101111 || in_op == 7'b1100111,
                               in_op == 7'b0000011};
        end
    end

    assign head_pd       = out_valid ? mem_pd[rd_ptr] : 3'b000;
    assign out_is_branch = head_pd[2];
    assign out_is_jump   = head_pd[1];
    assign out_is_load   = head_pd[0];
`else
    assign out_is_branch = 1'b0;
    assign out_is_jump   = 1'b0;
    assign out_is_load   = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed testbench for if_id_fetch_queue (DEPTH=2, XLEN=32).
// Covers reset, fill/full, drain, streaming across wrap, flush, async reset, predecode.
module tb_if_id_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_is_branch;
    logic        out_is_jump;
    logic        out_is_load;
    logic [1:0]  count;

    int vectors = 0;
    int miscompares = 0;

`ifdef IF_ID_PREDECODE_EN
    localparam bit PD = 1'b1;
`else
    localparam bit PD = 1'b0;
`endif

    if_id_fetch_queue #(.DEPTH(2), .XLEN(32), .NOP_INSTR(32'h00000013)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_instr      (in_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_is_branch (out_is_branch),
        .out_is_jump   (out_is_jump),
        .out_is_load   (out_is_load),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pd3();
        return {29'd0, out_is_branch, out_is_jump, out_is_load};
    endfunction

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        tick();
        tick();
        chk("rst_count_held", 32'(count), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h00000013);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pd", pd3(), 32'd0);

        // Fill to full
        in_valid = 1'b1; in_pc = 32'h00; in_instr = 32'h00500093;
        tick();
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_pc", out_pc, 32'h00);
        in_pc = 32'h04; in_instr = 32'h00a00113;
        tick();
        chk("full_count", 32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_pc", out_pc, 32'h00);
        chk("full_head_instr", out_instr, 32'h00500093);
        in_pc = 32'h08; in_instr = 32'hdeadbeef;
        tick();
        chk("full_reject_count", 32'(count), 32'd2);
        chk("full_reject_head", out_pc, 32'h00);

        // Drain
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain1_count", 32'(count), 32'd1);
        chk("drain1_pc", out_pc, 32'h04);
        chk("drain1_instr", out_instr, 32'h00a00113);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain2_count", 32'(count), 32'd0);
        chk("drain2_valid", 32'(out_valid), 32'd0);
        chk("drain2_instr", out_instr, 32'h00000013);
        chk("drain2_pc", out_pc, 32'h0);
        tick();
        chk("empty_pop_ignored", 32'(count), 32'd0);

        // Streaming at count 1 across pointer wrap
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h00; in_instr = 32'h10000000;
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("stream_head_pc", out_pc, 32'(4 * (i - 1)));
            chk("stream_head_instr", out_instr, 32'h10000000 | 32'(4 * (i - 1)));
            in_pc = 32'(4 * i); in_instr = 32'h10000000 | 32'(4 * i);
            tick();
            chk("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        chk("stream_last_pc", out_pc, 32'h14);
        tick();
        chk("stream_drained", 32'(count), 32'd0);

        // Flush while full with a push offered
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'h40; in_instr = 32'h00100093;
        tick();
        in_pc = 32'h44;
        tick();
        chk("preflush_count", 32'(count), 32'd2);
        flush = 1'b1; in_pc = 32'h20; in_instr = 32'h00200093;
        tick();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        tick();
        chk("postflush_count", 32'(count), 32'd1);
        chk("postflush_head", out_pc, 32'h20);
        // Flush wins over an accepted push and a pop
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h24;
        tick();
        chk("flush_pushpop_count", 32'(count), 32'd0);
        flush = 1'b0; out_ready = 1'b0;

        // Asynchronous reset mid-cycle
        in_pc = 32'h30;
        tick();
        in_valid = 1'b0;
        chk("prearst_count", 32'(count), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_instr", out_instr, 32'h00000013);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Predecode
        in_valid = 1'b1; in_pc = 32'h00; in_instr = 32'h00000463;
        tick();
        chk("pd_beq", pd3(), {29'd0, PD, 2'b00});
        out_ready = 1'b1; in_pc = 32'h04; in_instr = 32'h0080006f;
        tick();
        chk("pd_jal", pd3(), {29'd0, 1'b0, PD, 1'b0});
        in_pc = 32'h08; in_instr = 32'h00002083;
        tick();
        chk("pd_lw", pd3(), {29'd0, 2'b00, PD});
        in_valid = 1'b0;
        tick();
        chk("pd_empty", pd3(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Decoupling queue between the IF stage and the ID stage.
- Accepts fetched (pc, instr) pairs from IF through a valid/ready handshake and buffers up to DEPTH entries.
- Presents the oldest entry to ID.
- Absorbs ID back-pressure without forcing IF to re-fetch. Flush (branch redirect) discards all buffered instructions in one cycle.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, >= 2.
- XLEN, 32, width of pc and instr.
- NOP_INSTR, 32'h00000013, value driven on out_instr when the queue is empty.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  synchronous flush; discards all entries
- in_valid  in  1  IF presents a valid fetched instruction
- in_ready  out  1  queue can accept; IF stalls when 0
- in_pc  in  XLEN  PC of the fetched instruction
- in_instr  in  XLEN  fetched instruction word
- out_valid  out  1  head entry valid for ID
- out_ready  in  1  ID consumes head this cycle
- out_pc  out  XLEN  PC of the head entry
- out_instr  out  XLEN  instruction of the head entry
- out_is_branch  out  1  predecode: head opcode == 7'b1100011
- out_is_jump  out  1  predecode: head opcode == 7'b1101111 or 7'b1100111
- out_is_load  out  1  predecode: head opcode == 7'b0000011
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular array of DEPTH entries with wr_ptr and rd_ptr ($clog2(DEPTH) bits each) and count register. Pointers wrap modulo DEPTH naturally.
- Reset (reset = 0, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs: out_valid = 0, out_pc = 0, out_instr = NOP_INSTR, predecode bits = 0, in_ready = 1.
  - Array contents need not be cleared.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count < DEPTH), combinational from count only. No same-cycle pass-through when full: a pop while full does not raise in_ready until the next cycle.
- out_valid = (count != 0).
- out_pc and out_instr = entry[rd_ptr] when out_valid. When empty: out_pc = 0, out_instr = NOP_INSTR.
- Latency: an entry pushed at edge N appears on the outputs after edge N (visible in cycle N+1). There is no combinational in-to-out path.
- Clock-edge updates, in priority order:
  1. flush = 1: count = 0, wr_ptr = 0, rd_ptr = 0. A concurrent push and pop are both discarded.
  2. push and pop together: write entry[wr_ptr], wr_ptr++, rd_ptr++, count unchanged. Legal only when count >= 1, because pop requires out_valid.
  3. push only: write, wr_ptr++, count++.
  4. pop only: rd_ptr++, count--.
  5. Neither: hold all state.
- Boundaries:
  - Full (count == DEPTH): in_ready = 0; in_valid is ignored.
  - Empty: out_valid = 0; out_ready is ignored.
  - in_pc and in_instr are don't-care when in_valid = 0.
- Reset asserted mid-operation discards all entries immediately, with no dependency on clk.
- Predecode bits qualify with out_valid and are 0 when empty.
- Order is strictly FIFO; no entry is duplicated or reordered.

Optional Feature:
- Macro: IF_ID_PREDECODE_EN.
- Defined: out_is_branch, out_is_jump and out_is_load are computed from instr[6:0] at push time and stored as 3 extra bits per entry. They are presented with the head entry.
- Undefined: no extra storage; all three ports are tied to 0. Port list is unchanged.

Test Plan:
- Reset held low, then released; no other stimulus -> count = 0, out_valid = 0, out_instr = 32'h00000013, in_ready = 1.
- Push pc 0x00 instr 0x00500093, then pc 0x04 instr 0x00a00113, out_ready = 0 -> count = 2, in_ready = 0; head shows pc 0x00 instr 0x00500093; a third push is not accepted.
- From full, out_ready = 1 for 2 cycles -> outputs 0x00 then 0x04 in order; count 2 -> 1 -> 0; in_ready = 1 one cycle after the first pop.
- Continuous push and pop at count = 1 across 6 instructions (pc 0x00 to 0x14) -> count stays 1; outputs emerge in PC order across pointer wrap.
- Queue holding 2 entries, flush = 1 together with a push of pc 0x20 -> next cycle count = 0, out_valid = 0; pc 0x20 is absent. A following push of pc 0x20 becomes head.
- With IF_ID_PREDECODE_EN, push 0x00000463 (beq), 0x0080006f (jal), 0x00002083 (lw) -> predecode outputs branch/jump/load = 100, 010, 001 respectively. Without the macro, all three are 0.
